// File: rtl/wino_pkg.sv
// Shared types/constants for the F(2,3) Winograd output transform.
// Holds FSM state enum, A^T coefficients and output width growth.
package wino_pkg;

  localparam int GROW = 4;

  localparam int AT [2][4] = '{
    '{1, 1,  1,  0},
    '{0, 1, -1, -1}
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COL  = 2'd1,
    S_ROW  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/wino_output_xform_if.sv
// Tile in / result out valid-ready bundle.
// slave: DUT side; master: producer/consumer side.
interface wino_output_xform_if #(
  parameter int W  = 8,
  parameter int OW = W + 4
);
  logic            in_valid;
  logic            in_ready;
  logic [16*W-1:0] in_tile;
  logic            out_valid;
  logic            out_ready;
  logic [4*OW-1:0] out_tile;

  modport slave (
    input  in_valid, in_tile, out_ready,
    output in_ready, out_valid, out_tile
  );

  modport master (
    output in_valid, in_tile, out_ready,
    input  in_ready, out_valid, out_tile
  );
endinterface

// File: rtl/wino_at_pass.sv
// One A^T pass: 4 signed elements -> {a+b+c, b-c-d}.
// Ports: x[4] (IW bits signed), y[2] (RW bits signed, sign-extended).
module wino_at_pass
  import wino_pkg::*;
#(
  parameter int IW = 8,
  parameter int RW = 10
) (
  input  logic signed [IW-1:0] x [4],
  output logic signed [RW-1:0] y [2]
);

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      y[i] = '0;
      for (int k = 0; k < 4; k++) begin
        if (AT[i][k] > 0)
          y[i] = y[i] + RW'(x[k]);
        else if (AT[i][k] < 0)
          y[i] = y[i] - RW'(x[k]);
      end
    end
  end

endmodule

// File: rtl/wino_output_xform.sv
// F(2,3) output transform A^T*Y*A: 4 column cycles, 1 row cycle, hold.
// Ports: clk, rstn (sync, active-low), io (slave), busy.
// Build option: WINO_OUT_SAT_EN clips results to the W-bit range.
module wino_output_xform
  import wino_pkg::*;
#(
  parameter int W  = 8,
  parameter int OW = W + GROW
) (
  input  logic clk,
  input  logic rstn,
  wino_output_xform_if.slave io,
  output logic busy
);

  state_e state;
  logic [1:0] col;
  logic [4*OW-1:0] otile;

  logic signed [W-1:0]   ybuf  [16];
  logic signed [W-1:0]   col_x [4];
  logic signed [W+1:0]   col_y [2];
  logic signed [W+1:0]   t0    [4];
  logic signed [W+1:0]   t1    [4];
  logic signed [W+3:0]   r0    [2];
  logic signed [W+3:0]   r1    [2];

  function automatic logic [OW-1:0] fit(
    input logic signed [W+3:0] v
  );
`ifdef WINO_OUT_SAT_EN
    logic signed [W+3:0] hi;
    logic signed [W+3:0] lo;
    hi = {5'b00000, {(W-1){1'b1}}};
    lo = {5'b11111, {(W-1){1'b0}}};
    if (v > hi)
      return OW'(hi);
    else if (v < lo)
      return OW'(lo);
    else
      return OW'(v);
`else
    return OW'(v);
`endif
  endfunction

  // column c of Y: rows 0..3
  always_comb begin
    for (int k = 0; k < 4; k++)
      col_x[k] = ybuf[{2'(k), col}];
  end

  wino_at_pass #(.IW(W), .RW(W+2)) u_col (
    .x (col_x),
    .y (col_y)
  );

  wino_at_pass #(.IW(W+2), .RW(W+4)) u_row0 (
    .x (t0),
    .y (r0)
  );

  wino_at_pass #(.IW(W+2), .RW(W+4)) u_row1 (
    .x (t1),
    .y (r1)
  );

  assign io.in_ready  = (state == S_IDLE);
  assign io.out_valid = (state == S_HOLD);
  assign io.out_tile  = otile;
  assign busy         = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      col   <= '0;
      otile <= '0;
      for (int k = 0; k < 16; k++)
        ybuf[k] <= '0;
      for (int k = 0; k < 4; k++) begin
        t0[k] <= '0;
        t1[k] <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            for (int k = 0; k < 16; k++)
              ybuf[k] <= io.in_tile[k*W +: W];
            col   <= '0;
            state <= S_COL;
          end
        end
        S_COL: begin
          t0[col] <= col_y[0];
          t1[col] <= col_y[1];
          col     <= col + 2'd1;
          if (col == 2'd3)
            state <= S_ROW;
        end
        S_ROW: begin
          otile <= {fit(r1[1]), fit(r1[0]),
                    fit(r0[1]), fit(r0[0])};
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (io.out_ready)
            state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wino_output_xform.sv
// Scoreboard bench for wino_output_xform.
// Expected tiles come from an integer reference model.
module tb_wino_output_xform;

  localparam int W  = 8;
  localparam int OW = 12;

  logic clk = 0;
  logic rstn = 0;
  logic busy;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [4*OW-1:0] sb [$];
  int   acc_hist [$];
  int   acc_edge = 0;
  bit   pend = 0;
  logic prev_ov = 0;

  wino_output_xform_if #(.W(W), .OW(OW)) io ();

  wino_output_xform #(.W(W), .OW(OW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (io),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
`ifdef WINO_OUT_SAT_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
`endif
    return v;
  endfunction

  function automatic logic [4*OW-1:0] model(
    input logic [16*W-1:0] t
  );
    int y [4][4];
    int a [4];
    int b [4];
    int o [4];
    logic [4*OW-1:0] res;
    logic signed [W-1:0] e;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        e = t[(r*4+c)*W +: W];
        y[r][c] = int'(e);
      end
    for (int c = 0; c < 4; c++) begin
      a[c] = y[0][c] + y[1][c] + y[2][c];
      b[c] = y[1][c] - y[2][c] - y[3][c];
    end
    o[0] = a[0] + a[1] + a[2];
    o[1] = a[1] - a[2] - a[3];
    o[2] = b[0] + b[1] + b[2];
    o[3] = b[1] - b[2] - b[3];
    for (int k = 0; k < 4; k++)
      res[k*OW +: OW] = OW'(sat(o[k]));
    return res;
  endfunction

  function automatic int el(input logic [4*OW-1:0] t,
                            input int k);
    logic signed [OW-1:0] v;
    v = t[k*OW +: OW];
    return int'(v);
  endfunction

  always @(negedge clk) begin
    logic [4*OW-1:0] exp;
    if (rstn) begin
      if (io.in_valid && io.in_ready) begin
        sb.push_back(model(io.in_tile));
        acc_edge = cyc + 1;
        acc_hist.push_back(cyc + 1);
        pend = 1;
      end
      if (io.out_valid && !prev_ov) begin
        check("latency", pend ? cyc - acc_edge : -1, 5);
        pend = 0;
      end
      if (io.out_valid && io.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_empty", 1, 0);
        end else begin
          exp = sb.pop_front();
          for (int k = 0; k < 4; k++)
            check($sformatf("out%0d", k),
                  el(io.out_tile, k), el(exp, k));
        end
      end
    end
    prev_ov = io.out_valid;
  end

  task automatic send(input logic [16*W-1:0] t,
                      input bit keep);
    bit ok;
    ok = 0;
    io.in_valid = 1;
    io.in_tile  = t;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (io.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    if (!keep) io.in_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++)
      @(posedge clk);
    @(posedge clk); #1;
    check("drain", sb.size(), 0);
  endtask

  function automatic logic [16*W-1:0] fill(input int v);
    logic [16*W-1:0] t;
    for (int k = 0; k < 16; k++)
      t[k*W +: W] = W'(v);
    return t;
  endfunction

  initial begin
    logic [16*W-1:0] t;
    logic [4*OW-1:0] snap;
    bit seen;

    io.in_valid  = 0;
    io.in_tile   = '0;
    io.out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    @(negedge clk);
    check("rst_in_ready", io.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", io.out_valid, 0);
    check("rst_out_tile", io.out_tile, 0);

    // all ones
    send(fill(1), 0);
    drain();
    check("ones00", el(io.out_tile, 0), 9);
    check("ones01", el(io.out_tile, 1), -3);
    check("ones10", el(io.out_tile, 2), -3);
    check("ones11", el(io.out_tile, 3), 1);

    // single impulse at (1,1)
    t = '0;
    t[5*W +: W] = W'(5);
    send(t, 0);
    drain();
    for (int k = 0; k < 4; k++)
      check("imp", el(io.out_tile, k), 5);

    // extremes
    send(fill(127), 0);
    drain();
`ifdef WINO_OUT_SAT_EN
    check("max00", el(io.out_tile, 0), 127);
`else
    check("max00", el(io.out_tile, 0), 1143);
`endif
    send(fill(-128), 0);
    drain();
`ifdef WINO_OUT_SAT_EN
    check("min00", el(io.out_tile, 0), -128);
`else
    check("min00", el(io.out_tile, 0), -1152);
`endif

    // random tiles
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 16; k++)
        t[k*W +: W] = W'($urandom);
      send(t, 0);
    end
    drain();

    // stall in HOLD
    io.out_ready = 0;
    for (int k = 0; k < 16; k++)
      t[k*W +: W] = W'($urandom);
    send(t, 0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io.out_valid) begin
        seen = 1;
        break;
      end
    end
    check("hold_seen", seen, 1);
    snap = io.out_tile;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      io.in_valid = i[0];
      io.in_tile  = fill(i);
      @(negedge clk);
      check("hold_ov", io.out_valid, 1);
      check("hold_tile", io.out_tile, snap);
      check("hold_rdy", io.in_ready, 0);
    end
    @(posedge clk); #1;
    io.in_valid  = 0;
    io.out_ready = 1;
    drain();

    // reset while in COL at column 2
    send(fill(3), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    sb.delete();
    pend = 0;
    @(negedge clk);
    check("mid_in_ready", io.in_ready, 1);
    check("mid_busy", busy, 0);
    check("mid_out_valid", io.out_valid, 0);
    check("mid_out_tile", io.out_tile, 0);
    send(fill(2), 0);
    drain();

    // back-to-back with in_valid held high
    acc_hist.delete();
    send(fill(-7), 1);
    t[W-1:0] = '0;
    for (int k = 0; k < 16; k++)
      t[k*W +: W] = W'(k - 8);
    send(t, 0);
    drain();
    if (acc_hist.size() >= 2)
      check("b2b_period",
            acc_hist[acc_hist.size()-1]
            - acc_hist[acc_hist.size()-2], 7);
    else
      check("b2b_count", acc_hist.size(), 2);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
